// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - uart_rx line, control and received-byte signals (master = receiver side)
interface uart_rx_if;
    logic        en;
    logic        rx;
    logic [15:0] baud_div;
    logic        rd;
    logic [7:0]  data;
    logic        valid;
    logic        frame_err;
    logic        overrun;

    modport master (
        input  en, rx, baud_div, rd,
        output data, valid, frame_err, overrun
    );

    modport slave (
        output en, rx, baud_div, rd,
        input  data, valid, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with pop/valid byte holding register
// Optional 3-sample majority vote per bit: define UART_RX_MAJORITY_EN.
module uart_rx (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    logic [2:0]  state;
    logic        rx_s1;
    logic        rxs;
    logic        rxs_d;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  shift;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        frame_err_q;
    logic        overrun_q;

    logic in_frame;
    logic cnt_zero;
    logic samp;
    logic samp_bit;

    assign in_frame = (state == START) || (state == DATA) || (state == STOP);
    assign cnt_zero = (cnt == 16'd0);

`ifdef UART_RX_MAJORITY_EN
    // The vote window straddles the counter-zero cycle, so the decision lands one cycle later.
    logic rxs_d2;
    logic pend;
    assign samp     = pend;
    assign samp_bit = (rxs_d2 & rxs_d) | (rxs_d2 & rxs) | (rxs_d & rxs);
`else
    assign samp     = in_frame && cnt_zero;
    assign samp_bit = rxs;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rx_s1       <= 1'b1;
            rxs         <= 1'b1;
            rxs_d       <= 1'b1;
            cnt         <= 16'd0;
            idx         <= 3'd0;
            shift       <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            rxs_d2      <= 1'b1;
            pend        <= 1'b0;
`endif
        end else begin
            rx_s1       <= bus.rx;
            rxs         <= rx_s1;
            rxs_d       <= rxs;
            frame_err_q <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            rxs_d2      <= rxs_d;
            pend        <= in_frame && cnt_zero && bus.en;
`endif
            if (bus.rd) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end

            if (in_frame) begin
                cnt <= cnt_zero ? bus.baud_div : cnt - 16'd1;
            end

            if (!bus.en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rxs_d && !rxs) begin
                            cnt   <= bus.baud_div >> 1;
                            state <= START;
                        end
                    end
                    START: begin
                        if (samp) begin
                            if (samp_bit) begin
                                state <= IDLE;
                            end else begin
                                idx   <= 3'd0;
                                state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (samp) begin
                            shift <= {samp_bit, shift[7:1]};
                            idx   <= idx + 3'd1;
                            if (idx == 3'd7) begin
                                state <= STOP;
                            end
                        end
                    end
                    STOP: begin
                        if (samp) begin
                            if (samp_bit) begin
                                state <= IDLE;
                                // A pop in the same cycle frees the register for the new byte.
                                if (!valid_q || bus.rd) begin
                                    data_q  <= shift;
                                    valid_q <= 1'b1;
                                end else begin
                                    overrun_q <= 1'b1;
                                end
                            end else begin
                                frame_err_q <= 1'b1;
                                state       <= WAIT_HIGH;
                            end
                        end
                    end
                    WAIT_HIGH: begin
                        if (rxs) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;
    logic clk;
    logic rst;
    uart_rx_if bus();

    uart_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 99;
`else
    localparam int LAT = 98;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    int p = 10;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = -1;
    int ferr_cnt = 0;
    logic v_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.valid && !v_prev) rise_cyc = cyc;
        v_prev = bus.valid;
        if (bus.frame_err) ferr_cnt = ferr_cnt + 1;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_div(input int d);
        bus.baud_div = 16'(d);
        p = d + 1;
    endtask

    // Drives one frame cycle by cycle; glitch_at inverts one cycle, cut_at abandons the frame.
    task automatic send(input logic [7:0] b, input logic stop, input int glitch_at, input int cut_at);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 10 * p; i++) begin
            if (i == cut_at) return;
            bus.rx = fr[i / p] ^ (i == glitch_at);
            @(posedge clk);
            #1;
        end
        bus.rx = 1'b1;
    endtask

    task automatic pulse_rd();
        bus.rd = 1'b1;
        tick(1);
        bus.rd = 1'b0;
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        int t;
        t = 0;
        while (!bus.valid && t < 12 * p) begin
            tick(1);
            t++;
        end
        n_cmp++;
        if (bus.valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s valid: got %b expected 1 (timeout)", name, bus.valid);
        end else begin
            n_cmp++;
            if (bus.data !== exp) begin
                n_fail++;
                $display("FAIL %s data: got %h expected %h", name, bus.data, exp);
            end
        end
        pulse_rd();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b1;
        bus.rx = 1'b1;
        bus.rd = 1'b0;
        set_div(9);
        tick(4);
        n_cmp += 4;
        if (bus.data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", bus.data); end
        if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
        if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
        if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
        rst = 1'b0;
        tick(3);
    endtask

    task automatic test_single();
        set_div(9);
        rise_cyc = -1;
        ferr_cnt = 0;
        send(8'h55, 1'b1, -1, -1);
        tick(2);
        n_cmp += 4;
        if (rise_cyc - start_cyc != LAT) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", rise_cyc - start_cyc, LAT); end
        if (bus.data !== 8'h55) begin n_fail++; $display("FAIL single_data: got %h expected 55", bus.data); end
        if (ferr_cnt != 0) begin n_fail++; $display("FAIL single_frame_err: got %0d expected 0", ferr_cnt); end
        if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL single_overrun: got %b expected 0", bus.overrun); end
        pulse_rd();
        n_cmp++;
        if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL single_rd_clear: got %b expected 0", bus.valid); end
    endtask

    task automatic test_back_to_back();
        fork
            begin
                send(8'hA3, 1'b1, -1, -1);
                send(8'h0F, 1'b1, -1, -1);
            end
            begin
                pop_expect("b2b_first", 8'hA3);
                pop_expect("b2b_second", 8'h0F);
            end
        join
        tick(2);
        n_cmp++;
        if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b expected 0", bus.overrun); end
    endtask

    task automatic test_overrun();
        send(8'h11, 1'b1, -1, -1);
        tick(p);
        send(8'h22, 1'b1, -1, -1);
        tick(2);
        n_cmp += 3;
        if (bus.data !== 8'h11) begin n_fail++; $display("FAIL overrun_data: got %h expected 11", bus.data); end
        if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL overrun_valid: got %b expected 1", bus.valid); end
        if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b expected 1", bus.overrun); end
        pulse_rd();
        n_cmp += 2;
        if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL overrun_rd_valid: got %b expected 0", bus.valid); end
        if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_rd_flag: got %b expected 0", bus.overrun); end
    endtask

    task automatic test_frame_err();
        ferr_cnt = 0;
        send(8'h7E, 1'b0, -1, -1);
        bus.rx = 1'b0;
        tick(30 * p);
        bus.rx = 1'b1;
        tick(3 * p);
        n_cmp += 2;
        if (ferr_cnt != 1) begin n_fail++; $display("FAIL break_frame_err_count: got %0d expected 1", ferr_cnt); end
        if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL break_valid: got %b expected 0", bus.valid); end
        fork
            send(8'h3C, 1'b1, -1, -1);
            pop_expect("after_break", 8'h3C);
        join
    endtask

    task automatic test_glitch();
        set_div(15);
        ferr_cnt = 0;
        bus.rx = 1'b0;
        tick(3);
        bus.rx = 1'b1;
        tick(3 * p);
        n_cmp += 2;
        if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b expected 0", bus.valid); end
        if (ferr_cnt != 0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d expected 0", ferr_cnt); end
`ifdef UART_RX_MAJORITY_EN
        // rx cycle of the bit-2 centre: 1 + (baud_div >> 1) + 3*P
        fork
            send(8'hC3, 1'b1, 1 + 7 + 3 * 16, -1);
            pop_expect("majority_glitch", 8'hC3);
        join
`endif
        set_div(9);
        tick(p);
    endtask

    task automatic test_reset_mid_frame();
        send(8'h5A, 1'b1, -1, -1);
        tick(p);
        send(8'h99, 1'b1, -1, 5 * p + p / 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n_cmp += 3;
        if (bus.data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data: got %h expected 00", bus.data); end
        if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", bus.valid); end
        if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL rst_mid_overrun: got %b expected 0", bus.overrun); end
        bus.rx = 1'b1;
        tick(2 * p);
        fork
            send(8'h42, 1'b1, -1, -1);
            pop_expect("after_rst", 8'h42);
        join
        n_cmp++;
        if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL after_rst_overrun: got %b expected 0", bus.overrun); end
    endtask

    task automatic test_enable_mid_frame();
        ferr_cnt = 0;
        send(8'h99, 1'b1, -1, 5 * p + p / 2);
        bus.en = 1'b0;
        tick(3);
        bus.rx = 1'b1;
        bus.en = 1'b1;
        tick(12 * p);
        n_cmp += 2;
        if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL en_mid_valid: got %b expected 0", bus.valid); end
        if (ferr_cnt != 0) begin n_fail++; $display("FAIL en_mid_frame_err: got %0d expected 0", ferr_cnt); end
        fork
            send(8'hE1, 1'b1, -1, -1);
            pop_expect("after_en", 8'hE1);
        join
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_mid_frame();
        test_enable_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
